// File: rtl/nn_pkg.sv
// Shared widths, state encoding and helpers for the time-multiplexed neuron layer.
package nn_pkg;

    localparam int WEIGHT_W = 17;
    localparam int ACT_W    = 27;
    localparam int FAN_IN   = 9;
    localparam int WVEC_W   = WEIGHT_W * FAN_IN;
    localparam int AVEC_W   = ACT_W * FAN_IN;
    localparam int FCNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STORE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic [ACT_W-1:0] relu(input logic [ACT_W-1:0] v);
        return v[ACT_W-1] ? {ACT_W{1'b0}} : v;
    endfunction

endpackage

// File: rtl/neuron_weight_fetch.sv
// Streams FAN_IN sequential weight reads from a base address and captures each
// word one cycle after its read strobe into the slot it belongs to.
module neuron_weight_fetch
    import nn_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base,
    input  logic [WEIGHT_W-1:0] w_data,
    output logic                w_rd,
    output logic [ADDR_W-1:0]   w_addr,
    output logic [WVEC_W-1:0]   weights,
    output logic                last
);

    localparam logic [FCNT_W-1:0] RD_LAST  = FCNT_W'(FAN_IN - 1);
    localparam logic [FCNT_W-1:0] CAP_LAST = FCNT_W'(FAN_IN);

    logic [FCNT_W-1:0]               cnt_r;
    logic                            active_r;
    logic                            w_rd_r;
    logic [ADDR_W-1:0]               w_addr_r;
    logic [FAN_IN-1:0][WEIGHT_W-1:0] wreg_r;

    // Read strobe/address generation and delayed capture of returning words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {FCNT_W{1'b0}};
            active_r <= 1'b0;
            w_rd_r   <= 1'b0;
            w_addr_r <= {ADDR_W{1'b0}};
            wreg_r   <= {(FAN_IN*WEIGHT_W){1'b0}};
        end else if (start) begin
            cnt_r    <= {FCNT_W{1'b0}};
            active_r <= 1'b1;
            w_rd_r   <= 1'b1;
            w_addr_r <= base;
        end else if (active_r) begin
            cnt_r  <= cnt_r + FCNT_W'(1);
            w_rd_r <= (cnt_r < RD_LAST);
            if (cnt_r < RD_LAST) begin
                w_addr_r <= w_addr_r + ADDR_W'(1);
            end
            // Word returned now belongs to the read issued one cycle earlier
            if (cnt_r != {FCNT_W{1'b0}}) begin
                wreg_r[cnt_r - FCNT_W'(1)] <= w_data;
            end
            if (cnt_r == CAP_LAST) begin
                active_r <= 1'b0;
            end
        end else begin
            w_rd_r <= 1'b0;
        end
    end

    assign w_rd    = w_rd_r;
    assign w_addr  = w_addr_r;
    assign weights = wreg_r;
    assign last    = active_r && (cnt_r == CAP_LAST);

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Runs every neuron of a layer through one shared MAC+ReLU datapath:
// fetch weights, launch, wait (bounded), store the clamped result.
module neuron_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int ADDR_W      = 8,
    parameter int IDX_W       = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                layer_start,
    input  logic [AVEC_W-1:0]   in_vec,
    output logic                busy,
    output logic                layer_done,
    output logic                err,
    output logic                w_rd,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [WEIGHT_W-1:0] w_data,
    output logic                n_start,
    output logic [WVEC_W-1:0]   n_weights,
    output logic [AVEC_W-1:0]   n_inputs,
    input  logic                n_done,
    input  logic [ACT_W-1:0]    n_result,
    output logic                res_we,
    output logic [IDX_W-1:0]    res_addr,
    output logic [ACT_W-1:0]    res_data
);

    localparam int               TMO_W    = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t             state_r, next_state_s;
    logic [IDX_W-1:0]   idx_r, next_idx_s;
    logic [TMO_W-1:0]   tmo_r;
    logic               accept_s, tmo_hit_s, fetch_start_s, fetch_last_s;
    logic [ADDR_W-1:0]  base_s;
    logic               busy_r, layer_done_r, err_r, n_start_r, res_we_r;
    logic [IDX_W-1:0]   res_addr_r;
    logic [ACT_W-1:0]   res_data_r;
    logic [AVEC_W-1:0]  in_vec_r;

    neuron_weight_fetch #(.ADDR_W(ADDR_W)) u_fetch (
        .clk     (clk),
        .rst     (rst),
        .start   (fetch_start_s),
        .base    (base_s),
        .w_data  (w_data),
        .w_rd    (w_rd),
        .w_addr  (w_addr),
        .weights (n_weights),
        .last    (fetch_last_s)
    );

    // Next-state, neuron index and event decode
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        accept_s     = 1'b0;
        tmo_hit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (layer_start) begin
                    next_state_s = ST_FETCH;
                    next_idx_s   = {IDX_W{1'b0}};
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (fetch_last_s) begin
                    next_state_s = ST_LAUNCH;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_LAUNCH: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (n_done) begin
                    next_state_s = ST_STORE;
                end else if (tmo_r == TMO_LAST) begin
                    next_state_s = ST_STORE;
                    tmo_hit_s    = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_STORE: begin
                if (idx_r == LAST_IDX) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FETCH;
                    next_idx_s   = idx_r + IDX_W'(1);
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
        fetch_start_s = (next_state_s == ST_FETCH) && (state_r != ST_FETCH);
        base_s        = ADDR_W'(next_idx_s) * ADDR_W'(FAN_IN);
    end

    // State, index, timeout counter and state-aligned strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
            busy_r       <= 1'b0;
            layer_done_r <= 1'b0;
            n_start_r    <= 1'b0;
            res_we_r     <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            idx_r        <= next_idx_s;
            tmo_r        <= (state_r == ST_WAIT) ? tmo_r + TMO_W'(1) : {TMO_W{1'b0}};
            busy_r       <= next_state_s inside {ST_FETCH, ST_LAUNCH, ST_WAIT, ST_STORE};
            layer_done_r <= (next_state_s == ST_DONE);
            n_start_r    <= (next_state_s == ST_LAUNCH);
            res_we_r     <= (next_state_s == ST_STORE);
        end
    end

    // Input latch, sticky timeout flag and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_vec_r   <= {AVEC_W{1'b0}};
            err_r      <= 1'b0;
            res_addr_r <= {IDX_W{1'b0}};
            res_data_r <= {ACT_W{1'b0}};
        end else begin
            if (accept_s) begin
                in_vec_r <= in_vec;
                err_r    <= 1'b0;
            end else if (tmo_hit_s) begin
                err_r <= 1'b1;
            end
            // A timed-out neuron stores zero so the layer can still complete
            if ((state_r == ST_WAIT) && (next_state_s == ST_STORE)) begin
                res_addr_r <= idx_r;
                res_data_r <= tmo_hit_s ? {ACT_W{1'b0}} : relu(n_result);
            end
        end
    end

    assign busy       = busy_r;
    assign layer_done = layer_done_r;
    assign err        = err_r;
    assign n_start    = n_start_r;
    assign n_inputs   = in_vec_r;
    assign res_we     = res_we_r;
    assign res_addr   = res_addr_r;
    assign res_data   = res_data_r;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed and randomized layer runs against a weight memory, a variable-latency
// datapath model and a dot-product reference computed from memory contents.
module tb_neuron_layer_sequencer;
    import nn_pkg::*;

    localparam int NN  = 2;
    localparam int AW  = 8;
    localparam int IW  = 1;
    localparam int TMO = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                layer_start = 1'b0;
    logic [AVEC_W-1:0]   in_vec = '0;
    logic                busy, layer_done, err, w_rd, n_start, res_we;
    logic [AW-1:0]       w_addr;
    logic [WEIGHT_W-1:0] w_data = '0;
    logic [WVEC_W-1:0]   n_weights;
    logic [AVEC_W-1:0]   n_inputs;
    logic                n_done = 1'b0;
    logic [ACT_W-1:0]    n_result = '0;
    logic [IW-1:0]       res_addr;
    logic [ACT_W-1:0]    res_data;

    int checks = 0;
    int errors = 0;

    neuron_layer_sequencer #(.NUM_NEURONS(NN), .ADDR_W(AW), .IDX_W(IW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .layer_start(layer_start), .in_vec(in_vec),
        .busy(busy), .layer_done(layer_done), .err(err),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
        .n_start(n_start), .n_weights(n_weights), .n_inputs(n_inputs),
        .n_done(n_done), .n_result(n_result),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // Weight memory: one-cycle read latency
    logic signed [WEIGHT_W-1:0] mem [256];
    logic signed [ACT_W-1:0]    act [FAN_IN];
    always @(posedge clk) if (w_rd) w_data <= mem[w_addr];

    // Datapath model: per-neuron latency, optional forced result, optional hang
    int                      lat_a [NN];
    bit                      never_a [NN];
    bit                      ovr_en [NN];
    logic signed [ACT_W-1:0] ovr_val [NN];
    int                      run_base = 0;
    int                      dp_starts, dp_cnt, dp_j;
    bit                      dp_busy;
    logic signed [ACT_W-1:0] dp_res, dp_r;

    function automatic logic signed [ACT_W-1:0] dot(input logic [AVEC_W-1:0] iv, input logic [WVEC_W-1:0] wv);
        longint s = 0;
        for (int k = 0; k < FAN_IN; k++)
            s += longint'($signed(iv[ACT_W*k +: ACT_W])) * longint'($signed(wv[WEIGHT_W*k +: WEIGHT_W]));
        return ACT_W'(s);
    endfunction

    assign dp_j = (dp_starts - run_base) % NN;
    assign dp_r = ovr_en[dp_j] ? ovr_val[dp_j] : dot(n_inputs, n_weights);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_busy <= 1'b0; dp_cnt <= 0; dp_starts <= 0; n_done <= 1'b0;
        end else begin
            n_done <= 1'b0;
            if (n_start) begin
                dp_starts <= dp_starts + 1;
                if (never_a[dp_j]) dp_busy <= 1'b0;
                else if (lat_a[dp_j] == 1) begin n_done <= 1'b1; n_result <= dp_r; end
                else begin dp_busy <= 1'b1; dp_cnt <= lat_a[dp_j] - 1; dp_res <= dp_r; end
            end else if (dp_busy) begin
                if (dp_cnt == 1) begin n_done <= 1'b1; n_result <= dp_res; dp_busy <= 1'b0; end
                else dp_cnt <= dp_cnt - 1;
            end
        end
    end

    // Passive monitor, sampled on the falling edge
    int               cyc = 0, fetch_cyc = 0, nstart_cnt = 0, ldone_cnt = 0, busy_cyc = 0;
    bit               w_rd_prev = 1'b0;
    int               addr_q [$];
    int               gap_q [$];
    int               wa_q [$];
    logic [ACT_W-1:0] wd_q [$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        w_rd_prev <= w_rd;
        if (w_rd) addr_q.push_back(int'(w_addr));
        if (w_rd && !w_rd_prev) fetch_cyc <= cyc;
        if (n_start) begin gap_q.push_back(cyc - fetch_cyc); nstart_cnt <= nstart_cnt + 1; end
        if (res_we) begin wa_q.push_back(int'(res_addr)); wd_q.push_back(res_data); end
        if (layer_done) ldone_cnt <= ldone_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);       chk({tag, "_layer_done"}, layer_done, 0);
        chk({tag, "_err"}, err, 0);         chk({tag, "_w_rd"}, w_rd, 0);
        chk({tag, "_n_start"}, n_start, 0); chk({tag, "_res_we"}, res_we, 0);
        chk({tag, "_w_addr"}, w_addr, 0);   chk({tag, "_res_addr"}, res_addr, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_n_weights"}, n_weights, 0);
        chk({tag, "_n_inputs"}, n_inputs, 0);
    endtask

    task automatic load_data(input bit linear);
        for (int a = 0; a < 256; a++)
            mem[a] = linear ? WEIGHT_W'(a) : WEIGHT_W'(int'($urandom_range(200)) - 100);
        for (int k = 0; k < FAN_IN; k++) begin
            act[k] = linear ? ACT_W'(1) : ACT_W'(int'($urandom_range(200)) - 100);
            in_vec[ACT_W*k +: ACT_W] = act[k];
        end
    endtask

    task automatic set_ctrl(input int l0, input int l1, input bit nv1);
        lat_a[0] = l0; lat_a[1] = l1;
        never_a[0] = 1'b0; never_a[1] = nv1;
        ovr_en[0] = 1'b0; ovr_en[1] = 1'b0;
    endtask

    task automatic run_layer(input string tag, input bit mid_restart, input bit done_start);
        int b_addr = addr_q.size(), b_gap = gap_q.size(), b_wr = wa_q.size();
        int b_ns = nstart_cnt, b_ld = ldone_cnt, b_busy = busy_cyc;
        int busy_exp = 0, c = 0;
        bit err_exp = 1'b0;
        longint exp_res [NN];
        for (int i = 0; i < NN; i++) begin
            longint s = 0;
            for (int k = 0; k < FAN_IN; k++) s += longint'(act[k]) * longint'(mem[i*FAN_IN + k]);
            if (ovr_en[i]) s = longint'(ovr_val[i]);
            exp_res[i] = (never_a[i] || s < 0) ? 0 : s;
            err_exp |= never_a[i];
            busy_exp += 12 + (never_a[i] ? TMO : lat_a[i]);
        end
        run_base = dp_starts;
        @(negedge clk); layer_start = 1'b1;
        @(negedge clk); layer_start = 1'b0;
        chk({tag, "_busy_after_accept"}, busy, 1);
        chk({tag, "_err_cleared_on_accept"}, err, 0);
        if (mid_restart) begin
            while (!n_start && c < 200) begin @(negedge clk); c++; end
            @(negedge clk); layer_start = 1'b1;
            @(negedge clk); layer_start = 1'b0;
        end
        c = 0;
        while (!layer_done && c < 3000) begin @(negedge clk); c++; end
        chk({tag, "_layer_done_seen"}, layer_done, 1);
        if (done_start) begin
            layer_start = 1'b1;
            @(negedge clk); layer_start = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_idle_after_done"}, busy, 0);
        chk({tag, "_done_pulses"}, ldone_cnt - b_ld, 1);
        chk({tag, "_n_start_count"}, nstart_cnt - b_ns, NN);
        chk({tag, "_busy_cycles"}, busy_cyc - b_busy, busy_exp);
        chk({tag, "_err"}, err, err_exp);
        chk({tag, "_w_rd_count"}, addr_q.size() - b_addr, NN*FAN_IN);
        chk({tag, "_write_count"}, wa_q.size() - b_wr, NN);
        for (int j = 0; j < NN*FAN_IN && b_addr + j < addr_q.size(); j++)
            chk($sformatf("%s_w_addr%0d", tag, j), addr_q[b_addr + j], j);
        for (int i = 0; i < NN && b_gap + i < gap_q.size(); i++)
            chk($sformatf("%s_fetch_cycles%0d", tag, i), gap_q[b_gap + i], 10);
        for (int i = 0; i < NN && b_wr + i < wa_q.size(); i++) begin
            chk($sformatf("%s_res_addr%0d", tag, i), wa_q[b_wr + i], i);
            chk($sformatf("%s_res_data%0d", tag, i), wd_q[b_wr + i], ACT_W'(exp_res[i]));
        end
    endtask

    initial begin
        int c;
        int b_wr;
        rst = 1'b1;
        load_data(1'b1);
        set_ctrl(3, 3, 1'b0);
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // w[a]=a, all-ones activations: 36 and 117
        b_wr = wd_q.size();
        run_layer("basic", 1'b0, 1'b0);
        chk("basic_lit0", wd_q.size() > b_wr ? wd_q[b_wr] : '1, 36);
        chk("basic_lit1", wd_q.size() > b_wr + 1 ? wd_q[b_wr + 1] : '1, 117);

        // Negative result clamps without error; latency 64 is still in time
        load_data(1'b0);
        set_ctrl(1, TMO, 1'b0);
        ovr_en[0] = 1'b1; ovr_val[0] = -ACT_W'(5);
        run_layer("neg_clamp", 1'b0, 1'b0);

        // Neuron 1 never answers
        set_ctrl(2, 3, 1'b1);
        run_layer("timeout", 1'b0, 1'b0);

        // Re-pulse during WAIT and during DONE, both ignored; err cleared on accept
        load_data(1'b0);
        set_ctrl(6, 6, 1'b0);
        run_layer("restart_ignored", 1'b1, 1'b1);

        // Reset while fetching neuron 1
        load_data(1'b0);
        set_ctrl(3, 3, 1'b0);
        run_base = dp_starts;
        @(negedge clk); layer_start = 1'b1;
        @(negedge clk); layer_start = 1'b0;
        c = 0;
        while (!(w_rd && w_addr == AW'(11)) && c < 200) begin @(negedge clk); c++; end
        chk("rst_mid_reached_fetch1", w_addr, 11);
        b_wr = wa_q.size();
        #1 rst = 1'b1;
        #1 check_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_writes", wa_q.size() - b_wr, 0);
        chk("rst_mid_idle", busy, 0);
        run_layer("after_rst", 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            load_data(1'b0);
            set_ctrl(int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), $urandom_range(3) == 0);
            never_a[0] = ($urandom_range(4) == 0);
            run_layer($sformatf("rand%0d", r), 1'b0, 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
